// File: rtl/cla_pipe_addsub_pkg.sv
// Shared constants and the 4-bit carry-lookahead cell for the pipelined adder.
// cla4() returns the group sum, the carry into bit 3 and the group carry-out.
package cla_pipe_addsub_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  localparam int GRP_W      = 4;

  typedef struct packed {
    logic [3:0] s;
    logic       c3;
    logic       c4;
  } cla4_t;

  function automatic cla4_t cla4(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       c0
  );
    cla4_t      r;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    p    = a ^ b;
    g    = a & b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    r.s  = p ^ c[3:0];
    r.c3 = c[3];
    r.c4 = c[4];
    return r;
  endfunction

endpackage

// File: rtl/cla_pipe_stage.sv
// One registered slice: adds bits [K*SW +: SW] with a ripple of 4-bit CLA groups.
// Ports: adv_i load enable; *_i from previous stage; *_o registered to next.
module cla_pipe_stage
  import cla_pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int K      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic             c_i,
  output logic             v_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             ov_o,
  output logic             z_o
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / GRP_W;
  localparam int LO = K * SW;

  logic             v_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             ov_q;
  logic             z_q;

  logic [NG:0]      gc;
  logic             cm;
  cla4_t            r;
  logic [WIDTH-1:0] s_d;
  logic             ov_d;
  logic             z_d;

  always_comb begin
    gc    = '0;
    cm    = 1'b0;
    r     = '0;
    s_d   = s_i;
    gc[0] = c_i;
    for (int g = 0; g < NG; g++) begin
      r = cla4(a_i[LO+g*GRP_W +: GRP_W],
               b_i[LO+g*GRP_W +: GRP_W],
               gc[g]);
      s_d[LO+g*GRP_W +: GRP_W] = r.s;
      gc[g+1] = r.c4;
      // only the top group's c3 matters: carry into this slice's MSB
      cm = r.c3;
    end
    ov_d = cm ^ gc[NG];
    z_d  = (s_d == '0);
  end

  // data holds when a bubble passes so idle outputs keep their last value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q  <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      s_q  <= '0;
      c_q  <= 1'b0;
      ov_q <= 1'b0;
      z_q  <= 1'b0;
    end else if (adv_i) begin
      v_q <= v_i;
      if (v_i) begin
        a_q  <= a_i;
        b_q  <= b_i;
        s_q  <= s_d;
        c_q  <= gc[NG];
        ov_q <= ov_d;
        z_q  <= z_d;
      end
    end
  end

  assign v_o  = v_q;
  assign a_o  = a_q;
  assign b_o  = b_q;
  assign s_o  = s_q;
  assign c_o  = c_q;
  assign ov_o = ov_q;
  assign z_o  = z_q;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor, STAGES slices, valid/ready on both sides.
// Ports: in_valid/in_ready, a, b, ci, sub in; out_valid/out_ready, s, co, ov, zero out.
module cla_pipe_addsub
  import cla_pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov,
  output logic             zero
);

  logic             adv;
  logic             v_w  [STAGES+1];
  logic [WIDTH-1:0] a_w  [STAGES+1];
  logic [WIDTH-1:0] b_w  [STAGES+1];
  logic [WIDTH-1:0] s_w  [STAGES+1];
  logic             c_w  [STAGES+1];
  logic             ov_w [STAGES];
  logic             z_w  [STAGES];

  // whole pipe moves as one; a stalled output freezes every stage
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // subtract is A + ~B + 1; ci is ignored then
  assign v_w[0] = in_valid;
  assign a_w[0] = a;
  assign b_w[0] = sub ? ~b : b;
  assign s_w[0] = '0;
  assign c_w[0] = sub | ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_pipe_stage #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .K     (k)
    ) u_stage (
      .clk  (clk),
      .reset(reset),
      .adv_i(adv),
      .v_i  (v_w[k]),
      .a_i  (a_w[k]),
      .b_i  (b_w[k]),
      .s_i  (s_w[k]),
      .c_i  (c_w[k]),
      .v_o  (v_w[k+1]),
      .a_o  (a_w[k+1]),
      .b_o  (b_w[k+1]),
      .s_o  (s_w[k+1]),
      .c_o  (c_w[k+1]),
      .ov_o (ov_w[k]),
      .z_o  (z_w[k])
    );
  end

  assign out_valid = v_w[STAGES];
  assign s         = s_w[STAGES];
  assign co        = c_w[STAGES];
  assign ov        = ov_w[STAGES-1];
  assign zero      = z_w[STAGES-1];

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench: directed cases, backpressure, reset flush, random traffic.
// Reference is signed/unsigned integer arithmetic with an in-order queue.
module tb_cla_pipe_addsub;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        ci, sub;
  logic        out_valid, out_ready;
  logic [31:0] s;
  logic        co, ov, zero;

  logic        in_valid2, in_ready2;
  logic [15:0] a2, b2;
  logic        ci2, sub2;
  logic        out_valid2, out_ready2;
  logic [15:0] s2;
  logic        co2, ov2, zero2;

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ov(ov), .zero(zero)
  );

  cla_pipe_addsub #(.WIDTH(16), .STAGES(2)) u_dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .ci(ci2), .sub(sub2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .s(s2), .co(co2), .ov(ov2), .zero(zero2)
  );

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   tot = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_out = 0;
  bit   lat_chk = 1'b0;

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input logic sb);
    exp_t            e;
    longint          r;
    longint unsigned u;
    u = 0;
    if (sb) begin
      r    = longint'($signed(x)) - longint'($signed(y));
      e.co = (x >= y);
    end else begin
      r    = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      u    = 64'(x) + 64'(y) + 64'(c);
      e.co = u[32];
    end
    e.s   = r[31:0];
    e.ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.z   = (e.s == 32'h0);
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] x,
                       input logic [31:0] y, input logic c, input logic sb);
    in_valid = v;
    a        = x;
    b        = y;
    ci       = c;
    sub      = sb;
  endtask

  task automatic do_cycle();
    exp_t e;
    #1;
    if (in_valid && in_ready) begin
      e     = model(a, b, ci, sub);
      e.cyc = cyc;
      q.push_back(e);
    end
    if (out_valid && out_ready) begin
      n_out++;
      chk("out_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("s", 64'(s), 64'(e.s));
        chk("co", 64'(co), 64'(e.co));
        chk("ov", 64'(ov), 64'(e.ov));
        chk("zero", 64'(zero), 64'(e.z));
        if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'd4);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic rnd_op();
    drive(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom));
  endtask

  initial begin
    logic [31:0] hold;
    int          n0;
    hold = '0;
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    in_valid2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; sub2 = 1'b0;
    out_ready2 = 1'b1;

    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_co", 64'(co), 64'd0);
    chk("rst_ov", 64'(ov), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 16-bit, 2-stage: FFFF + 1 after exactly 2 cycles
    in_valid2 = 1'b1; a2 = 16'hFFFF; b2 = 16'h0001;
    #1;
    chk("w16_in_ready", 64'(in_ready2), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 1'b0;
    #1;
    chk("w16_not_yet", 64'(out_valid2), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("w16_valid", 64'(out_valid2), 64'd1);
    chk("w16_s", 64'(s2), 64'h0000);
    chk("w16_co", 64'(co2), 64'd1);
    chk("w16_zero", 64'(zero2), 64'd1);
    chk("w16_ov", 64'(ov2), 64'd0);
    @(negedge clk);

    // directed corner cases, latency checked
    lat_chk = 1'b1;
    drive(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0); do_cycle();
    drive(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0); do_cycle();
    drive(1'b1, 32'h00000005, 32'h00000007, 1'b1, 1'b1); do_cycle();
    drive(1'b1, 32'h80000000, 32'h00000001, 1'b0, 1'b1); do_cycle();
    drive(1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b1); do_cycle();
    drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0); do_cycle();
    drive(1'b1, 32'h0000FFFF, 32'h00000001, 1'b1, 1'b0); do_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) do_cycle();
    chk("directed_drained", 64'(q.size()), 64'd0);

    // 10 back-to-back, then 3 stalled cycles
    lat_chk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rnd_op();
      do_cycle();
    end
    rnd_op();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      if (j == 0) hold = s;
      else chk("stall_s_stable", 64'(s), 64'(hold));
      do_cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      out_ready = 1'($urandom);
      do_cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) do_cycle();
    chk("burst_drained", 64'(q.size()), 64'd0);

    // random traffic with random backpressure
    for (int i = 0; i < 80; i++) begin
      rnd_op();
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      do_cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) do_cycle();
    chk("random_drained", 64'(q.size()), 64'd0);

    // reset with 3 operations in flight
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_op();
      do_cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_s", 64'(s), 64'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n0 = n_out;
    drive(1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b1);
    do_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) do_cycle();
    chk("postrst_one_result", 64'(n_out - n0), 64'd1);
    chk("postrst_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits; must be a multiple of 4.
REQ-002 SHALL provide parameter STAGES, default 4, pipeline depth; must divide WIDTH/4 exactly.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: in_valid  input  1  operand set offered.
REQ-007 SHALL have port: in_ready  output  1  operand set accepted this cycle when high with in_valid.
REQ-008 SHALL have port: a  input  WIDTH  operand A.
REQ-009 SHALL have port: b  input  WIDTH  operand B.
REQ-010 SHALL have port: ci  input  1  carry-in; ignored when sub=1.
REQ-011 SHALL have port: sub  input  1  mode select, 0 = add, 1 = subtract (A-B).
REQ-012 SHALL have port: out_valid  output  1  result present.
REQ-013 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port: s  output  WIDTH  sum or difference.
REQ-015 SHALL have port: co  output  1  carry-out of MSB; for subtract, 1 = no borrow.
REQ-016 SHALL have port: ov  output  1  two's-complement signed overflow.
REQ-017 SHALL have port: zero  output  1  s equals 0.

Function
REQ-018 SHALL compute A + B' + c0, where B' = sub ? ~B : B and c0 = sub ? 1 : ci.
REQ-019 SHALL split the datapath into STAGES slices of WIDTH/STAGES bits; slice k SHALL be added in stage k from the registered carry of slice k-1.
REQ-020 SHALL build each slice from 4-bit carry-lookahead groups in a ripple-of-groups chain.
REQ-021 SHALL delay unprocessed upper operand bits, and already-computed lower sum bits, through stage registers alongside the carry.
REQ-022 SHALL keep one valid bit per stage.
REQ-023 SHALL set advance = !out_valid || out_ready; all stage registers load only when advance=1.
REQ-024 SHALL drive in_ready = advance combinationally; a transfer occurs when in_valid && in_ready.
REQ-025 SHALL load bubbles (valid=0) into stage 0 when advance=1 and in_valid=0.
REQ-026 SHALL give a latency of exactly STAGES cycles from accept to out_valid when out_ready stays high.
REQ-027 SHALL sustain throughput of one result per cycle.
REQ-028 SHALL hold s, co, ov, zero and out_valid stable while out_valid=1 and out_ready=0.
REQ-029 SHALL not lose, duplicate or reorder any result under any out_ready pattern.
REQ-030 SHALL compute ov = carry into MSB XOR carry out of MSB.
REQ-031 SHALL compute zero from the final s; zero SHALL be valid only with out_valid.
REQ-032 SHALL leave outputs at their last value when out_valid=0.
REQ-033 SHALL, when STAGES=1, reduce to a single registered adder with latency 1.

Reset
REQ-034 SHALL clear all stage valid bits, out_valid, s, co, ov and zero to 0 asynchronously on reset.
REQ-035 SHALL hold in_ready=1 during and immediately after reset, since out_valid=0.
REQ-036 SHALL discard all in-flight operations on reset mid-operation; no result from before reset SHALL appear afterwards.

Structure
REQ-037 SHALL place the default WIDTH and STAGES values and the group width (4) as constants in the shared ALU package/include.
REQ-038 SHALL use one sub-module, cla_pipe_stage (one registered slice: group chain plus stage registers), instantiated STAGES times by generate; the existing 4-bit CLA cell SHALL be reused inside it.

Verification
REQ-039 SHALL cover, with WIDTH=32, STAGES=4: a=FFFFFFFF, b=00000001, add, ci=0 -> after 4 cycles s=00000000, co=1, zero=1, ov=0.
REQ-040 SHALL cover: a=7FFFFFFF, b=00000001, add -> s=80000000, ov=1, co=0.
REQ-041 SHALL cover: a=5, b=7, sub=1, ci=1 (ignored) -> s=FFFFFFFE, co=0, ov=0; and a=80000000, b=1, sub=1 -> s=7FFFFFFF, ov=1, co=1.
REQ-042 SHALL cover: 10 back-to-back random operations, then out_ready held low for 3 cycles -> in_ready=0 throughout; all 10 results in order; no loss or duplicates.
REQ-043 SHALL cover: reset asserted with 3 operations in flight -> out_valid=0 immediately; next accepted operation emerges alone after 4 cycles.
REQ-044 SHALL cover: repeat REQ-039 with WIDTH=16, STAGES=2 -> s=0000, co=1, latency 2.
